// File: rtl/dpd_pkg.sv
// Shared definitions for the digital phase detector: FSM encoding, angle
// constants and the fold from a 0..359 degree phase to magnitude/direction.
package dpd_pkg;

    localparam int DEG_FULL = 360;
    localparam int DEG_HALF = 180;
    localparam int SHIFT_W  = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_DIVIDE,
        ST_REPORT
    } dpd_state_e;

    // Returns {direction, magnitude}: phases above half a turn are reported
    // as a lead of (360 - q) degrees.
    function automatic logic [SHIFT_W:0] fold_phase(input logic [SHIFT_W-1:0] q);
        logic [SHIFT_W-1:0] full;
        logic [SHIFT_W-1:0] half;
        full = SHIFT_W'(DEG_FULL);
        half = SHIFT_W'(DEG_HALF);
        if (q > half) begin
            return {1'b1, full - q};
        end
        return {1'b0, q};
    endfunction

endpackage

// File: rtl/dpd_serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The start cycle
// already performs the first step, so the quotient is complete and done_o
// is high exactly NUM_W cycles after the start cycle begins.
module dpd_serial_divider #(
    parameter int CNT_W = 16,
    parameter int NUM_W = CNT_W + 9,
    parameter int QUO_W = NUM_W
) (
    input  logic             aclk,
    input  logic             clr_i,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [CNT_W-1:0] den_i,
    output logic [QUO_W-1:0] quo_o,
    output logic             done_o
);

    localparam int STEP_W = $clog2(NUM_W);

    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [NUM_W-1:0]  quo_q, quo_d;
    logic [CNT_W-1:0]  den_q, den_d;
    logic [STEP_W-1:0] cnt_q;
    logic              run_q;

    logic [CNT_W:0]    trial;
    logic [CNT_W:0]    diff;
    logic              fits;
    logic              step_en;

    // One restoring step, fed from the operand ports on the start cycle and
    // from the working registers afterwards.
    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no latch is inferred.
        rem_d = start_i ? '0    : rem_q;
        quo_d = start_i ? num_i : quo_q;
        den_d = start_i ? den_i : den_q;
        trial = {rem_d, quo_d[NUM_W-1]};
        diff  = trial - {1'b0, den_d};
        fits  = (trial >= {1'b0, den_d});
        rem_d = fits ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
        quo_d = {quo_d[NUM_W-2:0], fits};
        step_en = start_i || (run_q && (cnt_q != '0));
    end

    // Step counter: counts the NUM_W-1 steps left after the start cycle.
    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (clr_i) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start_i) begin
            run_q <= 1'b1;
            cnt_q <= STEP_W'(NUM_W - 1);
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - STEP_W'(1);
            end
        end
    end

    // Working registers for remainder, shifting numerator/quotient and divisor.
    always_ff @(posedge aclk) begin
        // NOTE: pure datapath, left unreset; it is always reloaded by start_i before use.
        if (step_en) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            den_q <= den_d;
        end
    end

    assign done_o = run_q && (cnt_q == '0);
    assign quo_o  = quo_q[QUO_W-1:0];

endmodule

// File: rtl/digital_phase_detector.sv
// Digital phase detector: measures the phase of sig_in against ref_in over
// one ref period and reports it as a 0..180 degree magnitude plus direction.
// Optional macro DPD_SYNC_EN: adds a 2-flop synchronizer on both inputs.
module digital_phase_detector
    import dpd_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int MIN_PERIOD = 8
) (
    input  logic                      aclk,
    input  logic                      aclr,
    input  logic                      ref_in,
    input  logic                      sig_in,
    output logic signed [SHIFT_W-1:0] shift_amount,
    output logic                      direction,
    output logic                      valid,
    output logic                      error,
    output logic                      busy
);

    localparam int               NUM_W = CNT_W + SHIFT_W;
    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

    logic ref_cur, sig_cur;
    logic ref_hist_q, sig_hist_q;
    logic ref_rise, sig_rise;

`ifdef DPD_SYNC_EN
    logic [1:0] ref_sync_q, sig_sync_q;

    // Two-flop synchronizers; both paths see the same delay, so phase is unchanged.
    always_ff @(posedge aclk) begin
        ref_sync_q <= {ref_sync_q[0], ref_in};
        sig_sync_q <= {sig_sync_q[0], sig_in};
    end

    assign ref_cur = ref_sync_q[1];
    assign sig_cur = sig_sync_q[1];
`else
    assign ref_cur = ref_in;
    assign sig_cur = sig_in;
`endif

    // Input history for edge detection; it keeps tracking through reset so a
    // level that is already high when reset releases is not taken as a rise.
    always_ff @(posedge aclk) begin
        ref_hist_q <= ref_cur;
        sig_hist_q <= sig_cur;
    end

    assign ref_rise = ref_cur & ~ref_hist_q;
    assign sig_rise = sig_cur & ~sig_hist_q;

    dpd_state_e         state_q, state_d;
    logic [CNT_W-1:0]   per_q, per_d;
    logic [CNT_W-1:0]   dly_q, dly_d;
    logic               dly_ok_q, dly_ok_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               dir_q, dir_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    logic [CNT_W-1:0]   per_inc;
    logic               div_start;
    logic               div_done;
    logic [NUM_W-1:0]   div_num;
    logic [SHIFT_W-1:0] div_quo;

    dpd_serial_divider #(
        .CNT_W (CNT_W),
        .NUM_W (NUM_W),
        .QUO_W (SHIFT_W)
    ) u_div (
        .aclk    (aclk),
        .clr_i   (aclr),
        .start_i (div_start),
        .num_i   (div_num),
        .den_i   (per_inc),
        .quo_o   (div_quo),
        .done_o  (div_done)
    );

    // per_inc counts the current cycle, so a sig rise k cycles after the
    // opening ref rise captures k and a period of N cycles closes at N.
    assign per_inc = per_q + CNT_W'(1);
    assign div_num = NUM_W'(dly_q) * NUM_W'(DEG_FULL);

    // Next-state and output logic: measure, divide, then report one result.
    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        dly_d     = dly_q;
        dly_ok_d  = dly_ok_q;
        shift_d   = shift_q;
        dir_d     = dir_q;
        err_d     = err_q;
        valid_d   = 1'b0;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ref_rise) begin
                    state_d  = ST_MEASURE;
                    per_d    = '0;
                    dly_d    = '0;
                    dly_ok_d = sig_rise;
                end
            end
            ST_MEASURE: begin
                per_d = per_inc;
                if (ref_rise) begin
                    if ((per_inc < MIN_P) || !dly_ok_q) begin
                        state_d = ST_REPORT;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                        shift_d = '0;
                        dir_d   = 1'b0;
                    end else begin
                        state_d   = ST_DIVIDE;
                        div_start = 1'b1;
                    end
                end else if (per_inc == '1) begin
                    state_d = ST_REPORT;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    shift_d = '0;
                    dir_d   = 1'b0;
                end else if (sig_rise && !dly_ok_q) begin
                    dly_d    = per_inc;
                    dly_ok_d = 1'b1;
                end
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    state_d          = ST_REPORT;
                    valid_d          = 1'b1;
                    err_d            = 1'b0;
                    {dir_d, shift_d} = fold_phase(div_quo);
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge aclk) begin
        if (aclr) begin
            state_q  <= ST_IDLE;
            per_q    <= '0;
            dly_q    <= '0;
            dly_ok_q <= 1'b0;
            shift_q  <= '0;
            dir_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            dly_q    <= dly_d;
            dly_ok_q <= dly_ok_d;
            shift_q  <= shift_d;
            dir_q    <= dir_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign shift_amount = shift_q;
    assign direction    = dir_q;
    assign valid        = valid_q;
    assign error        = err_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_digital_phase_detector.sv
// Directed testbench for digital_phase_detector (CNT_W=16, MIN_PERIOD=8).
module tb_digital_phase_detector;

    logic              aclk;
    logic              aclr;
    logic              ref_in;
    logic              sig_in;
    logic signed [8:0] shift_amount;
    logic              direction;
    logic              valid;
    logic              error;
    logic              busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int period;
        int delay;
        bit sig_on;
        int shift;
        int dir;
        int err;
        int lat;
    } vec_t;

    vec_t vecs[8];

    digital_phase_detector #(
        .CNT_W      (16),
        .MIN_PERIOD (8)
    ) dut (
        .aclk         (aclk),
        .aclr         (aclr),
        .ref_in       (ref_in),
        .sig_in       (sig_in),
        .shift_amount (shift_amount),
        .direction    (direction),
        .valid        (valid),
        .error        (error),
        .busy         (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; k=0 is the opening ref rise and
    // k=period the closing one. sig rises at k=delay when enabled.
    task automatic drive_period(input int period, input int delay, input bit sig_on);
        repeat (3) begin
            @(negedge aclk);
            ref_in = 1'b0;
            sig_in = 1'b0;
        end
        for (int k = 0; k <= period; k++) begin
            @(negedge aclk);
            ref_in = (k == period) || (k < period / 2);
            sig_in = sig_on && (k >= delay) && (k < delay + period / 2);
        end
    endtask

    // Counts cycles after the last driven edge until valid; -1 on timeout.
    task automatic wait_valid(input int limit, output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int j = 1; j <= limit; j++) begin
            @(negedge aclk);
            if (!busy) busy_ok = 1'b0;
            if (valid) begin
                lat = j;
                break;
            end
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat;
        bit busy_ok;
        drive_period(v.period, v.delay, v.sig_on);
        wait_valid(1000, lat, busy_ok);
        check({name, "_latency"}, lat, v.lat);
        check({name, "_shift"}, shift_amount, v.shift);
        check({name, "_dir"}, direction, v.dir);
        check({name, "_error"}, error, v.err);
        check({name, "_busy"}, busy_ok, 1);
    endtask

    initial begin
        int   lat;
        int   n_valid;
        bit   busy_ok;
        vec_t post;

        vecs[0] = '{100,  0, 1'b0,   0, 0, 1,  1};  // sig held low
        vecs[1] = '{  4,  0, 1'b0,   0, 0, 1,  1};  // period below minimum
        vecs[2] = '{100, 25, 1'b1,  90, 0, 0, 26};
        vecs[3] = '{100, 75, 1'b1,  90, 1, 0, 26};
        vecs[4] = '{100, 50, 1'b1, 180, 0, 0, 26};
        vecs[5] = '{360,  1, 1'b1,   1, 0, 0, 26};
        vecs[6] = '{360,  0, 1'b1,   0, 0, 0, 26};
        vecs[7] = '{360,359, 1'b1,   1, 1, 0, 26};

        aclr   = 1'b1;
        ref_in = 1'b0;
        sig_in = 1'b0;
        repeat (4) @(negedge aclk);
        check("reset_valid", valid, 0);
        check("reset_shift", shift_amount, 0);
        check("reset_dir", direction, 0);
        check("reset_error", error, 0);
        check("reset_busy", busy, 0);
        aclr = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the middle of DIVIDE: outputs clear and no result appears.
        drive_period(100, 25, 1'b1);
        repeat (10) @(negedge aclk);
        check("mid_div_busy", busy, 1);
        aclr = 1'b1;
        @(negedge aclk);
        aclr = 1'b0;
        check("clr_valid", valid, 0);
        check("clr_shift", shift_amount, 0);
        check("clr_dir", direction, 0);
        check("clr_error", error, 0);
        check("clr_busy", busy, 0);
        n_valid = 0;
        repeat (40) begin
            @(negedge aclk);
            if (valid) n_valid++;
        end
        check("clr_no_valid", n_valid, 0);

        post = '{100, 25, 1'b1, 90, 0, 0, 26};
        run_vec("post_clr", post);

        // ref_in rises once and stays high: period counter saturates.
        repeat (3) begin
            @(negedge aclk);
            ref_in = 1'b0;
            sig_in = 1'b0;
        end
        @(negedge aclk);
        ref_in = 1'b1;
        wait_valid(70000, lat, busy_ok);
        check("stuck_latency", lat, 65536);
        check("stuck_shift", shift_amount, 0);
        check("stuck_dir", direction, 0);
        check("stuck_error", error, 1);
        check("stuck_busy", busy_ok, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
